// File: rtl/multicycle_control.sv
// Multicycle controller for a small MIPS-subset datapath.
//
// Sequences each instruction through FETCH / DECODE / EXEC / MEM / WB and
// drives the datapath strobes. The instruction register lives here; every
// field output (register addresses, shamt, imm16, addr26) comes from it,
// never from the live memory bus.
//
// Ports
//   clk, rst_n             rising-edge clock, async active-low reset
//   instruction            instruction memory read data, latched on imem_ack in FETCH
//   imem_ack, dmem_ack     fetch / data access complete
//   alu_zero               ALU result is zero (branch decision in EXEC)
//   imem_req               fetch request
//   dmem_read, dmem_write  load / store request, held until dmem_ack
//   ir_write, pc_write     IR latch and PC update strobes
//   pc_src                 0 PC+4, 1 branch target, 2 {PC[31:28],addr26,00}, 3 reg A
//   reg_write, wb_src      register write strobe; 0 ALU, 1 memory, 2 PC+4
//   alu_src, alu_op        ALU operand select and operation
//   addr_a/addr_b/addr_in  register file read / write addresses
//   shamt, imm16, addr26   instruction fields for the datapath
//   illegal                one-cycle pulse in DECODE for unsupported encodings
//   state                  current FSM state code
//
// state  | meaning
// FETCH  | request instruction, wait for imem_ack, latch IR and PC+4
// DECODE | classify IR; unsupported encodings pulse illegal, back to FETCH
// EXEC   | ALU operation, branch decision, jump and link write
// MEM    | load/store request held until dmem_ack
// WB     | register file write for ALU ops and loads
// 5..7   | unreachable; return to FETCH

`ifndef OP_ADD
`define OP_ADD 3'd0
`endif
`ifndef OP_SUB
`define OP_SUB 3'd1
`endif
`ifndef OP_AND
`define OP_AND 3'd2
`endif
`ifndef OP_OR
`define OP_OR 3'd3
`endif
`ifndef OP_NOR
`define OP_NOR 3'd4
`endif
`ifndef OP_SLT
`define OP_SLT 3'd5
`endif
`ifndef OP_SLL
`define OP_SLL 3'd6
`endif
`ifndef OP_SRL
`define OP_SRL 3'd7
`endif
`ifndef ALU_SRC_DATA_B
`define ALU_SRC_DATA_B 2'd0
`endif
`ifndef ALU_SRC_SEXT
`define ALU_SRC_SEXT 2'd1
`endif
`ifndef ALU_SRC_ZEXT
`define ALU_SRC_ZEXT 2'd2
`endif

module multicycle_control #(
   parameter int REG_ADDR_W = 5,
   parameter int ALU_OP_W   = 3,
   parameter bit LINK_EN    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           instruction,
   input  logic                  imem_ack,
   input  logic                  dmem_ack,
   input  logic                  alu_zero,
   output logic                  imem_req,
   output logic                  dmem_read,
   output logic                  dmem_write,
   output logic                  ir_write,
   output logic                  pc_write,
   output logic [1:0]            pc_src,
   output logic                  reg_write,
   output logic [1:0]            wb_src,
   output logic [1:0]            alu_src,
   output logic [ALU_OP_W-1:0]   alu_op,
   output logic [REG_ADDR_W-1:0] addr_a,
   output logic [REG_ADDR_W-1:0] addr_b,
   output logic [REG_ADDR_W-1:0] addr_in,
   output logic [4:0]            shamt,
   output logic [15:0]           imm16,
   output logic [25:0]           addr26,
   output logic                  illegal,
   output logic [2:0]            state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   typedef enum logic [4:0] {
      I_ILL, I_ADD, I_SUB, I_AND, I_OR, I_NOR, I_SLT, I_SLL, I_SRL, I_JR,
      I_JALR, I_ADDI, I_ANDI, I_ORI, I_LW, I_SW, I_BEQ, I_BNE, I_J, I_JAL
   } kind_t;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(`OP_ADD);
   localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(`OP_SUB);
   localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(`OP_AND);
   localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(`OP_OR);
   localparam logic [ALU_OP_W-1:0] ALU_NOR = ALU_OP_W'(`OP_NOR);
   localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(`OP_SLT);
   localparam logic [ALU_OP_W-1:0] ALU_SLL = ALU_OP_W'(`OP_SLL);
   localparam logic [ALU_OP_W-1:0] ALU_SRL = ALU_OP_W'(`OP_SRL);

   localparam logic [1:0] SRC_DATA_B = `ALU_SRC_DATA_B;
   localparam logic [1:0] SRC_SEXT   = `ALU_SRC_SEXT;
   localparam logic [1:0] SRC_ZEXT   = `ALU_SRC_ZEXT;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_REG    = 2'd3;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_LINK = 2'd2;

   localparam logic [REG_ADDR_W-1:0] R_LINK = REG_ADDR_W'(5'd31);

   state_t                  state_q, state_d;
   logic [31:0]             ir_q;
   logic                    ir_load;
   kind_t                   kind;
   logic [5:0]              opcode, funct;
   logic [REG_ADDR_W-1:0]   rs, rt, rd;

   logic [ALU_OP_W-1:0]     op_k;
   logic [1:0]              src_k;
   logic                    is_shift, is_load, is_store, is_branch;
   logic                    is_jump, is_jreg, is_link, dest_rd, taken;

   assign opcode  = ir_q[31:26];
   assign funct   = ir_q[5:0];
   assign rs      = REG_ADDR_W'(ir_q[25:21]);
   assign rt      = REG_ADDR_W'(ir_q[20:16]);
   assign rd      = REG_ADDR_W'(ir_q[15:11]);
   assign ir_load = (state_q == S_FETCH) && imem_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         if (ir_load) begin
            ir_q <= instruction;
         end
      end
   end

   always_comb begin
      kind = I_ILL;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h20:   kind = I_ADD;
               6'h22:   kind = I_SUB;
               6'h24:   kind = I_AND;
               6'h25:   kind = I_OR;
               6'h27:   kind = I_NOR;
               6'h2A:   kind = I_SLT;
               6'h00:   kind = I_SLL;
               6'h02:   kind = I_SRL;
               6'h08:   kind = I_JR;
               6'h09:   kind = I_JALR;
               default: kind = I_ILL;
            endcase
         end
         6'h08:   kind = I_ADDI;
         6'h0C:   kind = I_ANDI;
         6'h0D:   kind = I_ORI;
         6'h23:   kind = I_LW;
         6'h2B:   kind = I_SW;
         6'h04:   kind = I_BEQ;
         6'h05:   kind = I_BNE;
         6'h02:   kind = I_J;
         6'h03:   kind = I_JAL;
         default: kind = I_ILL;
      endcase
   end

   always_comb begin
      op_k      = ALU_ADD;
      src_k     = SRC_DATA_B;
      is_shift  = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      is_jump   = 1'b0;
      is_jreg   = 1'b0;
      is_link   = 1'b0;
      dest_rd   = 1'b0;
      case (kind)
         I_ADD:  begin op_k = ALU_ADD; dest_rd = 1'b1; end
         I_SUB:  begin op_k = ALU_SUB; dest_rd = 1'b1; end
         I_AND:  begin op_k = ALU_AND; dest_rd = 1'b1; end
         I_OR:   begin op_k = ALU_OR;  dest_rd = 1'b1; end
         I_NOR:  begin op_k = ALU_NOR; dest_rd = 1'b1; end
         I_SLT:  begin op_k = ALU_SLT; dest_rd = 1'b1; end
         I_SLL:  begin op_k = ALU_SLL; dest_rd = 1'b1; is_shift = 1'b1; end
         I_SRL:  begin op_k = ALU_SRL; dest_rd = 1'b1; is_shift = 1'b1; end
         I_JR:   begin is_jump = 1'b1; is_jreg = 1'b1; end
         I_JALR: begin is_jump = 1'b1; is_jreg = 1'b1; is_link = 1'b1; end
         I_ADDI: begin op_k = ALU_ADD; src_k = SRC_SEXT; end
         I_ANDI: begin op_k = ALU_AND; src_k = SRC_ZEXT; end
         I_ORI:  begin op_k = ALU_OR;  src_k = SRC_ZEXT; end
         I_LW:   begin op_k = ALU_ADD; src_k = SRC_SEXT; is_load = 1'b1; end
         I_SW:   begin op_k = ALU_ADD; src_k = SRC_SEXT; is_store = 1'b1; end
         I_BEQ:  begin op_k = ALU_SUB; is_branch = 1'b1; end
         I_BNE:  begin op_k = ALU_SUB; is_branch = 1'b1; end
         I_J:    begin is_jump = 1'b1; end
         I_JAL:  begin is_jump = 1'b1; is_link = 1'b1; end
         default: ;
      endcase
   end

   assign taken = (kind == I_BEQ) ? alu_zero : ~alu_zero;

   always_comb begin
      state_d    = S_FETCH;
      imem_req   = 1'b0;
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SEQ;
      reg_write  = 1'b0;
      wb_src     = WB_ALU;
      alu_src    = SRC_DATA_B;
      alu_op     = '0;
      addr_a     = rs;
      addr_b     = rt;
      addr_in    = '0;
      shamt      = '0;
      imm16      = ir_q[15:0];
      addr26     = ir_q[25:0];
      illegal    = 1'b0;
      state      = state_q;

      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               pc_src   = PC_SEQ;
               state_d  = S_DECODE;
            end else begin
               state_d  = S_FETCH;
            end
         end
         S_DECODE: begin
            if (kind == I_ILL) begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_op  = op_k;
            alu_src = src_k;
            if (is_shift) begin
               shamt = ir_q[10:6];
            end
            if (is_branch) begin
               if (taken) begin
                  pc_write = 1'b1;
                  pc_src   = PC_BRANCH;
               end
               state_d = S_FETCH;
            end else if (is_jump) begin
               pc_write = 1'b1;
               pc_src   = is_jreg ? PC_REG : PC_JUMP;
               if (LINK_EN && is_link) begin
                  reg_write = 1'b1;
                  wb_src    = WB_LINK;
                  addr_in   = is_jreg ? rd : R_LINK;
               end
               state_d = S_FETCH;
            end else if (is_load || is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dmem_read  = is_load;
            dmem_write = is_store;
            if (dmem_ack) begin
               state_d = is_load ? S_WB : S_FETCH;
            end else begin
               state_d = S_MEM;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            addr_in   = dest_rd ? rd : rt;
            wb_src    = is_load ? WB_MEM : WB_ALU;
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // Reset kills every output combinationally, so an outstanding memory
      // request drops without waiting for a clock edge.
      if (!rst_n) begin
         state_d    = S_FETCH;
         imem_req   = 1'b0;
         dmem_read  = 1'b0;
         dmem_write = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         pc_src     = '0;
         reg_write  = 1'b0;
         wb_src     = '0;
         alu_src    = '0;
         alu_op     = '0;
         addr_a     = '0;
         addr_b     = '0;
         addr_in    = '0;
         shamt      = '0;
         imm16      = '0;
         addr26     = '0;
         illegal    = 1'b0;
         state      = '0;
      end
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter REG_ADDR_W, default 5: register-file address width; rs/rt/rd are the low REG_ADDR_W bits of instruction fields [25:21]/[20:16]/[15:11].
REQ-002 Parameter ALU_OP_W, default 3: alu_op width; encodings are the `OP_* values, zero-extended.
REQ-003 Parameter LINK_EN, default 1: 1 enables JAL/JALR link write; 0 makes JAL/JALR plain J/JR.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-005 Data ports SHALL be:
- instruction input 32: memory read data, captured on imem_ack.
- imem_ack input 1: instruction fetch complete.
- dmem_ack input 1: data access complete.
- alu_zero input 1: ALU result == 0.
- imem_req output 1: fetch request.
- dmem_read output 1: load request.
- dmem_write output 1: store request.
- ir_write output 1: latch IR.
- pc_write output 1: update PC.
- pc_src output 2: 0 = PC+4, 1 = branch target, 2 = {PC[31:28],addr26,00}, 3 = register A.
- reg_write output 1: register-file write strobe.
- wb_src output 2: 0 = ALU, 1 = memory data, 2 = PC+4.
- alu_src output 2: `ALU_SRC_* encoding.
- alu_op output ALU_OP_W.
- addr_a / addr_b / addr_in outputs REG_ADDR_W.
- shamt output 5.
- imm16 output 16.
- addr26 output 26.
- illegal output 1: unsupported-instruction pulse.
- state output 3: current FSM state.

Function
REQ-006 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge.
REQ-007 FETCH: imem_req=1 while waiting; on imem_ack=1, ir_write=1, pc_write=1 with pc_src=0, next state DECODE; otherwise hold FETCH.
REQ-008 The IR SHALL be held internally; imm16, addr26, shamt, addr_a, addr_b and addr_in SHALL be derived from the IR, not from the live instruction input.
REQ-009 DECODE SHALL take exactly one cycle and classify the IR; supported instructions go to EXEC; unsupported opcode/func pulses illegal for 1 cycle and goes to FETCH with no write strobes.
REQ-010 Supported instructions:
- R-type ADD, SUB, AND, OR, NOR, SLT, SLL, SRL, JR, JALR.
- ADDI, ANDI, ORI, LW, SW, BEQ, BNE, J, JAL.
REQ-011 EXEC, ALU-class instructions: set alu_op/alu_src (ADDI, LW, SW sign-extend; ANDI, ORI zero-extend; R-type DATA_B); shamt = IR[10:6] for SLL/SRL, else 0; next state WB, or MEM for LW/SW.
REQ-012 EXEC, BEQ/BNE: alu_op=`OP_SUB, alu_src=DATA_B; pc_write=1 with pc_src=1 if alu_zero==1 for BEQ or ==0 for BNE; next state FETCH.
REQ-013 EXEC, J/JAL/JR/JALR: pc_write=1 with pc_src=2 (J/JAL) or 3 (JR/JALR); if LINK_EN, reg_write=1 with wb_src=2, addr_in=31 for JAL and rd for JALR; next state FETCH.
REQ-014 MEM: dmem_read (LW) or dmem_write (SW) SHALL stay high until dmem_ack; on ack, SW goes to FETCH and LW goes to WB; no ack means hold.
REQ-015 WB: reg_write=1 for one cycle; addr_in = rd (R-type) or rt (I-type/LW); wb_src = 1 for LW, else 0; next state FETCH.
REQ-016 A write with addr_in==0 SHALL still assert reg_write; discarding it is the register file's job.
REQ-017 Unconditional latencies, with acks returned in the same cycle:
- Branch/jump: 3 cycles.
- ALU or SW: 4 cycles.
- LW: 5 cycles.
- Each ack-wait cycle adds 1.
REQ-018 Strobes SHALL be Moore outputs of state plus IR, except pc_write/pc_src in EXEC, which also depend on alu_zero, and ir_write/pc_write in FETCH, which depend on imem_ack.
REQ-019 imem_req, dmem_read and dmem_write SHALL never be high in the same cycle.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state=FETCH, IR=0, and every output to 0, including mid-MEM with a request outstanding.
REQ-021 On the first clk edge after rst_n rises, imem_req SHALL be 1.

Verification
REQ-022 Reset released, ADDI $2,$1,5 with immediate ack -> DECODE, EXEC, WB; reg_write=1 in WB with addr_in=2, alu_src=SEXT, imm16=0x0005; back in FETCH 4 cycles after ack.
REQ-023 LW with dmem_ack delayed 3 cycles -> dmem_read held high 4 cycles in MEM, then WB with wb_src=1, addr_in=rt.
REQ-024 BEQ with alu_zero=1 -> pc_write=1, pc_src=1 in EXEC; with alu_zero=0 -> pc_write=0; both end in FETCH with no reg_write.
REQ-025 JAL with LINK_EN=1 -> pc_src=2, reg_write=1, addr_in=31, wb_src=2; with LINK_EN=0 -> reg_write=0.
REQ-026 Opcode 0x3F -> illegal pulses 1 cycle in DECODE, no strobes, back to FETCH.
REQ-027 rst_n dropped during MEM with dmem_write=1 -> dmem_write=0 immediately, without waiting for a clock edge; state=FETCH.
